// File: rtl/bullcow_pkg.sv
// bullcow_pkg
//   Shared definitions for the Bulls-and-Cows input conditioner:
//   digit geometry, debounce FSM state encoding and the repeated-digit
//   check applied to a captured guess.
package bullcow_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int CODE_W     = NUM_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } dbnc_state_t;

  // High when any two of the four nibbles are equal (6 pairwise compares).
  function automatic logic has_dup_digit(input logic [CODE_W-1:0] code);
    logic dup;
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (code[i*DIGIT_W +: DIGIT_W] == code[j*DIGIT_W +: DIGIT_W]) begin
          dup = 1'b1;
        end
      end
    end
    return dup;
  endfunction

endpackage

// File: rtl/bullcow_input_conditioner_debounce.sv
// button_debounce
//   Synchronises a raw push-button, debounces it with a four-state FSM and
//   produces one strobe per accepted press.
//   Ports:
//     clock        in   sole clock, rising edge
//     reset        in   synchronous, active-high
//     enter        in   raw asynchronous button, high = pressed
//     press_event  out  combinational "press accepted on this edge" (derived
//                       from flops only); lets the parent capture data on the
//                       same edge that launches enter_pulse
//     enter_pulse  out  registered one-cycle strobe per debounced press
module button_debounce
  import bullcow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic press_event,
  output logic enter_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  logic             enter_s;
  dbnc_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  assign enter_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], enter};
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_event = 1'b0;

    case (state_q)
      IDLE: begin
        if (enter_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!enter_s) begin
          // Bounce: fall back without a pulse.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          press_event = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!enter_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (enter_s) begin
          // Release bounce: back to HELD, no new pulse.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pulse_d = press_event;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign enter_pulse = pulse_q;

endmodule

// File: rtl/bullcow_input_conditioner.sv
// bullcow_input_conditioner
//   Front end of the Bulls-and-Cows game: synchronises the enter button and
//   the 16 switches, debounces enter, and on each accepted press captures the
//   synchronised switch value together with a repeated-digit flag.
//   Ports:
//     clock        in   sole clock, rising edge
//     reset        in   synchronous, active-high
//     enter        in   raw asynchronous push-button, high = pressed
//     SW[15:0]     in   raw asynchronous switches, digit 3 = SW[15:12]
//     enter_pulse  out  one-cycle strobe per debounced press
//     code_out     out  guess captured at the last press
//     code_dup     out  high when any two nibbles of code_out are equal
module bullcow_input_conditioner
  import bullcow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic [CODE_W-1:0] SW,
  output logic              enter_pulse,
  output logic [CODE_W-1:0] code_out,
  output logic              code_dup
);

  logic [CODE_W-1:0] sw_meta_q, sw_meta_d;
  logic [CODE_W-1:0] sw_s_q, sw_s_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              dup_q, dup_d;
  logic              press_event;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .enter       (enter),
    .press_event (press_event),
    .enter_pulse (enter_pulse)
  );

  // Capture happens on the same edge that raises enter_pulse, so the guess
  // and its flag are valid during the pulse cycle.
  always_comb begin
    sw_meta_d = SW;
    sw_s_d    = sw_meta_q;
    code_d    = code_q;
    dup_d     = dup_q;
    if (press_event) begin
      code_d = sw_s_q;
      dup_d  = has_dup_digit(sw_s_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      code_q    <= '0;
      dup_q     <= 1'b0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
      code_q    <= code_d;
      dup_q     <= dup_d;
    end
  end

  assign code_out = code_q;
  assign code_dup = dup_q;

endmodule

// File: tb/tb_bullcow_input_conditioner.sv
module tb_bullcow_input_conditioner;

  localparam int D = 4;
  // A press or release is accepted after this many consecutive synchronised
  // samples at the same level (one to leave the rest state, D to count).
  localparam int STABLE_EDGES = D + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        enter;
  logic [15:0] SW;
  logic        enter_pulse;
  logic [15:0] code_out;
  logic        code_dup;

  int checks = 0;
  int errors = 0;

  bullcow_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .enter       (enter),
    .SW          (SW),
    .enter_pulse (enter_pulse),
    .code_out    (code_out),
    .code_dup    (code_dup)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic        m_e1, m_e2;
  logic [15:0] m_sw1, m_sw2;
  bit          m_pressed;
  int          m_run;
  logic        exp_pulse;
  logic [15:0] exp_code;
  logic        exp_dup;
  int          model_pulses = 0;

  function automatic logic dup_ref(input logic [15:0] c);
    bit   seen [16];
    logic r;
    logic [3:0] d;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = c[i*4 +: 4];
      if (seen[d]) r = 1'b1;
      seen[d] = 1'b1;
    end
    return r;
  endfunction

  // Run-length view: count consecutive synchronised samples at the level
  // opposite to the current (released/pressed) state.
  always @(posedge clock) begin
    if (reset) begin
      m_e1 <= 1'b0; m_e2 <= 1'b0; m_sw1 <= '0; m_sw2 <= '0;
      m_pressed <= 1'b0; m_run <= 0;
      exp_pulse <= 1'b0; exp_code <= '0; exp_dup <= 1'b0;
    end else begin
      m_e1 <= enter; m_e2 <= m_e1; m_sw1 <= SW; m_sw2 <= m_sw1;
      exp_pulse <= 1'b0;
      if (m_e2 != m_pressed) begin
        if (m_run + 1 >= STABLE_EDGES) begin
          m_run <= 0;
          m_pressed <= ~m_pressed;
          if (!m_pressed) begin
            exp_pulse <= 1'b1;
            exp_code <= m_sw2;
            exp_dup <= dup_ref(m_sw2);
            model_pulses <= model_pulses + 1;
          end
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enter = 1'b0; SW = 16'hFFFF;
    repeat (3) @(negedge clock);
    checks++; if (enter_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse actual=%0b required=0", enter_pulse); end
    checks++; if (code_out !== 16'h0000) begin errors++; $display("FAIL reset_code actual=%h required=0000", code_out); end
    checks++; if (code_dup !== 1'b0) begin errors++; $display("FAIL reset_dup actual=%0b required=0", code_dup); end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    checks++; if (code_out !== 16'h0000) begin errors++; $display("FAIL reset_idle_code actual=%h required=0000", code_out); end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    int npulse = 0;
    int pidx = -1;
    SW = 16'h1234; enter = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 20) enter = 1'b0;
      @(negedge clock);
      checks++; if (enter_pulse !== exp_pulse) begin errors++; $display("FAIL clean_pulse cyc=%0d actual=%0b required=%0b", i, enter_pulse, exp_pulse); end
      checks++; if (code_out !== exp_code) begin errors++; $display("FAIL clean_code cyc=%0d actual=%h required=%h", i, code_out, exp_code); end
      if (enter_pulse === 1'b1) begin npulse++; pidx = i; end
    end
    checks++; if (npulse != 1) begin errors++; $display("FAIL clean_count actual=%0d required=1", npulse); end
    checks++; if (pidx != D + 2) begin errors++; $display("FAIL clean_latency actual=%0d required=%0d", pidx, D + 2); end
    checks++; if (code_out !== 16'h1234) begin errors++; $display("FAIL clean_code_final actual=%h required=1234", code_out); end
    checks++; if (code_dup !== 1'b0) begin errors++; $display("FAIL clean_dup actual=%0b required=0", code_dup); end
    $display("test_clean_press pulses=%0d at=%0d code=%h", npulse, pidx, code_out);
  endtask

  task automatic test_bounce();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int npulse = 0;
    SW = 16'h4321;
    for (int i = 0; i < 16; i++) begin
      enter = (i < 4) ? pat[i] : 1'b0;
      @(negedge clock);
      checks++; if (enter_pulse !== exp_pulse) begin errors++; $display("FAIL bounce_pulse cyc=%0d actual=%0b required=%0b", i, enter_pulse, exp_pulse); end
      if (enter_pulse === 1'b1) npulse++;
    end
    checks++; if (npulse != 0) begin errors++; $display("FAIL bounce_count actual=%0d required=0", npulse); end
    checks++; if (code_out !== 16'h1234) begin errors++; $display("FAIL bounce_code actual=%h required=1234", code_out); end
    $display("test_bounce pulses=%0d code=%h", npulse, code_out);
  endtask

  task automatic test_release_bounce();
    int npulse = 0;
    int waited = 0;
    SW = 16'h5678; enter = 1'b1;
    while (npulse == 0 && waited < 20) begin
      @(negedge clock);
      waited++;
      checks++; if (enter_pulse !== exp_pulse) begin errors++; $display("FAIL relb_pulse cyc=%0d actual=%0b required=%0b", waited, enter_pulse, exp_pulse); end
      if (enter_pulse === 1'b1) npulse++;
    end
    checks++; if (npulse != 1) begin errors++; $display("FAIL relb_timeout actual=%0d required=1", npulse); end
    for (int i = 0; i < 13; i++) begin
      enter = (i == 2) ? 1'b1 : 1'b0;
      @(negedge clock);
      checks++; if (enter_pulse !== exp_pulse) begin errors++; $display("FAIL relb_pulse2 cyc=%0d actual=%0b required=%0b", i, enter_pulse, exp_pulse); end
      if (enter_pulse === 1'b1) npulse++;
    end
    checks++; if (npulse != 1) begin errors++; $display("FAIL relb_count actual=%0d required=1", npulse); end
    checks++; if (code_out !== 16'h5678) begin errors++; $display("FAIL relb_code actual=%h required=5678", code_out); end
    $display("test_release_bounce pulses=%0d code=%h", npulse, code_out);
  endtask

  task automatic test_dup_digits();
    logic [15:0] codes [2] = '{16'h1231, 16'h9876};
    logic        dups  [2] = '{1'b1, 1'b0};
    for (int t = 0; t < 2; t++) begin
      int npulse = 0;
      SW = codes[t];
      for (int i = 0; i < 22; i++) begin
        enter = (i < 10) ? 1'b1 : 1'b0;
        @(negedge clock);
        checks++; if (code_dup !== exp_dup) begin errors++; $display("FAIL dup_model cyc=%0d actual=%0b required=%0b", i, code_dup, exp_dup); end
        if (enter_pulse === 1'b1) npulse++;
      end
      checks++; if (npulse != 1) begin errors++; $display("FAIL dup_count actual=%0d required=1", npulse); end
      checks++; if (code_out !== codes[t]) begin errors++; $display("FAIL dup_code actual=%h required=%h", code_out, codes[t]); end
      checks++; if (code_dup !== dups[t]) begin errors++; $display("FAIL dup_flag actual=%0b required=%0b", code_dup, dups[t]); end
      $display("test_dup_digits code=%h dup=%0b", code_out, code_dup);
    end
  endtask

  task automatic test_held();
    int npulse = 0;
    SW = 16'hABCD; enter = 1'b1;
    for (int i = 0; i < 115; i++) begin
      if (i >= 10) SW = 16'($urandom);
      if (i == 100) enter = 1'b0;
      @(negedge clock);
      checks++; if (enter_pulse !== exp_pulse) begin errors++; $display("FAIL held_pulse cyc=%0d actual=%0b required=%0b", i, enter_pulse, exp_pulse); end
      if (enter_pulse === 1'b1) npulse++;
    end
    checks++; if (npulse != 1) begin errors++; $display("FAIL held_count actual=%0d required=1", npulse); end
    checks++; if (code_out !== 16'hABCD) begin errors++; $display("FAIL held_code actual=%h required=abcd", code_out); end
    checks++; if (code_dup !== 1'b0) begin errors++; $display("FAIL held_dup actual=%0b required=0", code_dup); end
    $display("test_held pulses=%0d code=%h", npulse, code_out);
  endtask

  task automatic test_reset_mid();
    int npulse = 0;
    int pidx = -1;
    SW = 16'h2468; enter = 1'b1;
    // Edges k..k+3; PRESS_WAIT is entered at k+2, reset is sampled at k+4.
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (enter_pulse !== 1'b0) begin errors++; $display("FAIL rmid_pulse actual=%0b required=0", enter_pulse); end
    checks++; if (code_out !== 16'h0000) begin errors++; $display("FAIL rmid_code actual=%h required=0000", code_out); end
    checks++; if (code_dup !== 1'b0) begin errors++; $display("FAIL rmid_dup actual=%0b required=0", code_dup); end
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) enter = 1'b0;
      @(negedge clock);
      checks++; if (enter_pulse !== exp_pulse) begin errors++; $display("FAIL rmid_model cyc=%0d actual=%0b required=%0b", i, enter_pulse, exp_pulse); end
      if (enter_pulse === 1'b1) begin npulse++; pidx = i; end
    end
    checks++; if (npulse != 1) begin errors++; $display("FAIL rmid_count actual=%0d required=1", npulse); end
    checks++; if (pidx != D + 2) begin errors++; $display("FAIL rmid_latency actual=%0d required=%0d", pidx, D + 2); end
    checks++; if (code_out !== 16'h2468) begin errors++; $display("FAIL rmid_code2 actual=%h required=2468", code_out); end
    $display("test_reset_mid pulses=%0d at=%0d code=%h", npulse, pidx, code_out);
  endtask

  task automatic test_random();
    int run_left = 0;
    int npulse = 0;
    int model_start;
    model_start = model_pulses;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        enter = ~enter;
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      // Small digit range so repeated digits occur often.
      SW = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clock);
      checks++; if (enter_pulse !== exp_pulse) begin errors++; $display("FAIL rand_pulse cyc=%0d actual=%0b required=%0b", i, enter_pulse, exp_pulse); end
      checks++; if (code_out !== exp_code) begin errors++; $display("FAIL rand_code cyc=%0d actual=%h required=%h", i, code_out, exp_code); end
      checks++; if (code_dup !== exp_dup) begin errors++; $display("FAIL rand_dup cyc=%0d actual=%0b required=%0b", i, code_dup, exp_dup); end
      if (enter_pulse === 1'b1) npulse++;
    end
    reset = 1'b0;
    checks++; if (npulse != model_pulses - model_start) begin errors++; $display("FAIL rand_count actual=%0d required=%0d", npulse, model_pulses - model_start); end
    $display("test_random pulses=%0d", npulse);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_dup_digits();
    test_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
